// File: rtl/prbs8_burst_ctrl.sv
// Burst sequencer for an external free-running PRBS8 generator (x^8+x^6+x^5+x^4+1).
// Optional period self-check is built when PRBS_PERIOD_CHK_EN is defined.
module prbs8_burst_ctrl #(
   parameter int unsigned LEN_W    = 16,
   parameter logic [7:0]  FIX_SEED = 8'h01
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             start,
   input  logic             abort,
   input  logic [7:0]       seed,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             seed_fix,
   output logic             err_period,
   output logic             gen_ld,
   output logic [7:0]       gen_data,
   input  logic [7:0]       gen_prn,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [7:0]       seed_q, seed_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             seed_fix_q, seed_fix_d;
   logic             out_valid_q, out_valid_d;

   logic             start_acc;
   logic             xfer;
   logic             last_word;

   assign start_acc = (state_q == ST_IDLE) && start;
   assign xfer      = out_valid_q && out_ready;
   assign last_word = (cnt_q == LEN_W'(len_q - LEN_W'(1)));

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      seed_d      = seed_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      seed_fix_d  = seed_fix_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               seed_d     = (seed == 8'h00) ? FIX_SEED : seed;
               seed_fix_d = (seed == 8'h00);
               len_d      = len;
               cnt_d      = '0;
               state_d    = (len == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_d = abort ? ST_IDLE : ST_RUN;
         end
         ST_RUN: begin
            if (xfer) begin
               cnt_d = cnt_q + LEN_W'(1);
            end
            if (abort) begin
               state_d = ST_IDLE;
            end else if (xfer && last_word) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d      = (state_d == ST_LOAD) || (state_d == ST_RUN);
      done_d      = (state_d == ST_DONE);
      out_valid_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q     <= ST_IDLE;
         seed_q      <= 8'h00;
         len_q       <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         seed_fix_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         seed_q      <= seed_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         seed_fix_q  <= seed_fix_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Generator has no enable: a stall holds it by reloading its current word
   always_comb begin
      gen_ld   = 1'b0;
      gen_data = 8'h00;
      if (state_q == ST_LOAD) begin
         gen_ld   = 1'b1;
         gen_data = seed_q;
      end else if (out_valid_q && !out_ready) begin
         gen_ld   = 1'b1;
         gen_data = gen_prn;
      end
   end

`ifdef PRBS_PERIOD_CHK_EN
   localparam logic [7:0] PERIOD_LAST = 8'd254;

   logic [7:0] pcnt_q, pcnt_d;
   logic       err_period_q, err_period_d;

   // Every 255th delivered word must reproduce the burst seed
   always_comb begin
      pcnt_d       = pcnt_q;
      err_period_d = err_period_q;
      if (start_acc) begin
         pcnt_d       = 8'd0;
         err_period_d = 1'b0;
      end else if (xfer) begin
         pcnt_d = (pcnt_q == PERIOD_LAST) ? 8'd0 : pcnt_q + 8'd1;
         if ((pcnt_q == 8'd0) && (cnt_q != '0) && (gen_prn != seed_q)) begin
            err_period_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         pcnt_q       <= 8'd0;
         err_period_q <= 1'b0;
      end else begin
         pcnt_q       <= pcnt_d;
         err_period_q <= err_period_d;
      end
   end

   assign err_period = err_period_q;
`else
   assign err_period = 1'b0;
`endif

   assign busy      = busy_q;
   assign done      = done_q;
   assign seed_fix  = seed_fix_q;
   assign out_valid = out_valid_q;
   assign out_data  = gen_prn;

endmodule
